// File: rtl/pc_seq_if.sv
// Control/status bundle between the CPU core (master) and the PC sequencer (slave).
// Carries the link-register read/write port alongside the sequencing controls.
interface pc_seq_if;
   logic       stall;
   logic       halt_req;
   logic       resume;
   logic       jmp;
   logic       call;
   logic       ret;
   logic       br_en;
   logic       br_cond;
   logic [7:0] br_off;
   logic [7:0] tgt_addr;
   logic [7:0] lr;
   logic [7:0] pc;
   logic       lr_en;
   logic [7:0] lr_in;
   logic       halted;
   logic       stk_err;

   modport master (
      output stall, halt_req, resume, jmp, call, ret, br_en, br_cond, br_off, tgt_addr, lr,
      input  pc, lr_en, lr_in, halted, stk_err
   );

   modport slave (
      input  stall, halt_req, resume, jmp, call, ret, br_en, br_cond, br_off, tgt_addr, lr,
      output pc, lr_en, lr_in, halted, stk_err
   );
endinterface

// File: rtl/pc_seq.sv
// 8-bit program-counter sequencer with stall and halt/resume control.
// Define RET_STACK_EN to add an internal STK_DEPTH-entry return stack behind the link register.
module pc_seq #(
   parameter logic [7:0] RESET_PC  = 8'h00,
   parameter int         STK_DEPTH = 4
) (
   input logic     clk,
   input logic     rst,
   pc_seq_if.slave bus
);

   typedef enum logic {RUN, HALT} state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic       lr_en_c;
   logic [7:0] lr_in_c;
   logic [7:0] pc_inc;

   if (STK_DEPTH < 2 || STK_DEPTH > 8 || (STK_DEPTH & (STK_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pc_seq: STK_DEPTH must be a power of two in 2..8");
   end

   assign pc_inc = pc_q + 8'd1;

`ifdef RET_STACK_EN
   localparam int PTR_W = $clog2(STK_DEPTH);

   logic [7:0]       stk_mem [STK_DEPTH];
   logic [PTR_W-1:0] top_q;
   logic [PTR_W:0]   cnt_q;
   logic             stk_err_q;
   logic             push_c, pop_c;
   logic             stk_empty, stk_full;
   logic [7:0]       stk_top;

   assign stk_empty = (cnt_q == '0);
   assign stk_full  = (cnt_q == (PTR_W + 1)'(STK_DEPTH));
   assign stk_top   = stk_mem[top_q - PTR_W'(1)];

   // Circular buffer: a push when full overwrites the oldest slot, which is exactly the slot top_q points at.
   always_ff @(posedge clk) begin
      if (rst) begin
         top_q     <= '0;
         cnt_q     <= '0;
         stk_err_q <= 1'b0;
      end else if (push_c) begin
         stk_mem[top_q] <= bus.lr;
         top_q          <= top_q + PTR_W'(1);
         if (stk_full) stk_err_q <= 1'b1;
         else          cnt_q     <= cnt_q + (PTR_W + 1)'(1);
      end else if (pop_c) begin
         if (stk_empty) begin
            stk_err_q <= 1'b1;
         end else begin
            top_q <= top_q - PTR_W'(1);
            cnt_q <= cnt_q - (PTR_W + 1)'(1);
         end
      end
   end

   assign bus.stk_err = stk_err_q;
`else
   assign bus.stk_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next-PC selection; the instruction seen in the cycle halt_req is accepted still completes.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      lr_en_c = 1'b0;
      lr_in_c = pc_inc;
`ifdef RET_STACK_EN
      push_c  = 1'b0;
      pop_c   = 1'b0;
`endif
      case (state_q)
         RUN: begin
            if (!bus.stall) begin
               if (bus.ret) begin
                  pc_d = bus.lr;
`ifdef RET_STACK_EN
                  pop_c   = 1'b1;
                  lr_en_c = 1'b1;
                  lr_in_c = stk_empty ? 8'h00 : stk_top;
`endif
               end else if (bus.call) begin
                  pc_d    = bus.tgt_addr;
                  lr_en_c = 1'b1;
                  lr_in_c = pc_inc;
`ifdef RET_STACK_EN
                  push_c  = 1'b1;
`endif
               end else if (bus.jmp) begin
                  pc_d = bus.tgt_addr;
               end else if (bus.br_en && bus.br_cond) begin
                  pc_d = pc_q + bus.br_off;
               end else begin
                  pc_d = pc_inc;
               end
               if (bus.halt_req) state_d = HALT;
            end
         end
         HALT: begin
            if (bus.resume) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // Reset must not leave a write pending on the link register or the stack.
      if (rst) begin
         lr_en_c = 1'b0;
`ifdef RET_STACK_EN
         push_c  = 1'b0;
         pop_c   = 1'b0;
`endif
      end
   end

   assign bus.pc     = pc_q;
   assign bus.halted = (state_q == HALT);
   assign bus.lr_en  = lr_en_c;
   assign bus.lr_in  = lr_in_c;

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- 8-bit program-counter sequencer for the single-cycle CPU; sits directly upstream of the link register.
- Computes the next PC from increment, jump, relative branch, call and return.
- Drives the link register write port (lr_en, lr_in) on calls and reads LR back on returns.
- Adds stall and halt/resume control so the core can be frozen by memory or debug logic.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- STK_DEPTH, 4, return-stack depth when RET_STACK_EN is defined (power of two, 2..8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- stall  input  1  hold PC; all control inputs are ignored this cycle.
- halt_req  input  1  enter HALT after the current instruction completes.
- resume  input  1  leave HALT.
- jmp  input  1  absolute jump to tgt_addr.
- call  input  1  absolute call to tgt_addr; saves return address.
- ret  input  1  return to LR.
- br_en  input  1  conditional branch instruction present.
- br_cond  input  1  branch condition result from the ALU flags.
- br_off  input  8  signed two's-complement branch offset.
- tgt_addr  input  8  jump/call target.
- lr  input  8  current link register value (read port).
- pc  output  8  current program counter (registered).
- lr_en  output  1  link register write enable (combinational).
- lr_in  output  8  link register write data (combinational).
- halted  output  1  high while in HALT (registered).
- stk_err  output  1  sticky return-stack over/underflow flag (registered).

Behaviour:
- Reset (rst high at an edge): pc=RESET_PC; state=RUN; halted=0; stk_err=0; stack pointer=0. Overrides everything, including mid-stall and HALT.
- States:
  - RUN: normal sequencing.
  - HALT: pc held; lr_en=0; all control inputs ignored; halted=1.
- Transitions:
  - RUN -> HALT at the edge where halt_req=1 and stall=0. The instruction presented in that same cycle still executes and updates pc/LR.
  - HALT -> RUN at the edge where resume=1. Execution restarts at the held pc.
  - halt_req and resume both high in HALT: resume wins.
- Stall: when stall=1 (RUN only), pc holds, lr_en=0, and halt_req is not sampled. Stall beats every other input.
- Next-PC priority in RUN with stall=0: ret > call > jmp > (br_en & br_cond) > increment.
  - ret: pc <= lr.
  - call: pc <= tgt_addr; lr_en=1, lr_in=pc+1 in the same cycle, so the link register captures it on the same edge as the pc update.
  - jmp: pc <= tgt_addr.
  - branch taken: pc <= pc + sign-extended br_off, mod 256.
  - otherwise: pc <= pc+1.
- Arithmetic is 8-bit with wrap-around: 8'hFF+1=8'h00; pc=8'h02 with br_off=8'hFC gives 8'hFE.
- Call return address wraps the same way: call at 8'hFF gives lr_in=8'h00.
- ret and call both high: ret wins; lr_en=0 (without stack).
- lr_en is 0 in every case not listed above.

Optional Feature:
- Macro: RET_STACK_EN.
- Defined:
  - Internal STK_DEPTH x 8 return stack for nesting beyond one level.
  - On call: push the current lr value, then write pc+1 to LR as normal.
  - On ret: pc <= lr; lr_en=1; lr_in=popped top.
  - Push when full: the oldest entry is discarded and stk_err is set.
  - Pop when empty: lr_in=8'h00 and stk_err is set.
  - stk_err stays set until reset.
  - ret+call both high: ret behaviour only.
- Not defined: no stack storage; stk_err tied 0; ret never asserts lr_en.

Test Plan:
- Reset then 3 free cycles -> pc 00,01,02,03; lr_en=0 throughout; assert rst at pc=03 -> pc=00 next edge.
- pc=10, call with tgt_addr=40 -> same cycle lr_en=1, lr_in=11; next edge pc=40; later ret with lr=11 -> pc=11.
- pc=FF free-run -> pc=00. pc=02, br_en=1, br_cond=1, br_off=FC -> pc=FE. br_cond=0 -> pc=03.
- stall held 2 cycles with call=1, pc=20 -> pc stays 20, lr_en=0; stall released -> call executes.
- halt_req with jmp to 80 -> pc=80, halted=1; inputs ignored for 3 cycles; resume -> halted=0, pc increments from 80.
- RET_STACK_EN, STK_DEPTH=4: 5 nested calls -> stk_err=1; 5 returns -> LR values in LIFO order, final pop gives lr_in=00.
